// File: rtl/skinny_2shares_dec_top.sv
// Two-share SKINNY-128-384+ decryption core, one inverse round per cycle.
// A run rolls the tweakey schedule forward to round 40 (PREP), then peels
// off 40 inverse rounds (DEC) while rewinding the schedule back to round 1.
module skinny_2shares_dec_top (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [255:0] cipher_i,
  input  logic [255:0] key_i,
  input  logic [127:0] tweak1_i,
  input  logic [127:0] tweak2_i,
  output logic [255:0] plain_o,
  output logic         done_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_DEC  = 2'd2
  } fsm_e;

  localparam logic [5:0] LAST_PREP = 6'd38;
  localparam logic [5:0] LAST_DEC  = 6'd39;
  localparam logic [5:0] RC_INIT   = 6'h01;

  fsm_e         fsm_q, fsm_d;
  logic [5:0]   cnt_q, cnt_d;
  logic [5:0]   rc_q, rc_d;
  logic         done_q, done_d;
  logic [255:0] st_q, st_d;
  logic [255:0] tk3_q, tk3_d;
  logic [127:0] tk1_q, tk1_d;
  logic [127:0] tk2_q, tk2_d;
  logic [127:0] rk0, rk1;

  // ---------------------------------------------------------------------
  // S-box helpers. The forward S-box is four NOR/XOR layers separated by a
  // bit permutation, with a plain bit1/bit2 swap after the last layer. The
  // NOR/XOR layer is an involution, so the inverse replays the layers in
  // reverse order using the inverse permutation.
  // ---------------------------------------------------------------------
  function automatic logic [7:0] nor_xor(input logic [7:0] x);
    logic [7:0] y;
    y    = x;
    y[4] = x[4] ^ ~(x[7] | x[6]);
    y[0] = x[0] ^ ~(x[3] | x[2]);
    return y;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] b);
    logic [7:0] x;
    x = {b[7:3], b[1], b[2], b[0]};
    for (int i = 0; i < 3; i++) begin
      x = nor_xor(x);
      x = {x[5], x[4], x[0], x[3], x[1], x[7], x[6], x[2]};
    end
    return nor_xor(x);
  endfunction

  // Inverse MixColumns, inverse ShiftRows, round-key add, inverse SubCells.
  function automatic logic [127:0] inv_round(input logic [127:0] s,
                                             input logic [127:0] rk);
    logic [31:0]  m0, m1, m2, m3;
    logic [31:0]  x0, x1, x2, x3;
    logic [127:0] t;
    logic [127:0] o;
    m0 = s[127:96];
    m1 = s[95:64];
    m2 = s[63:32];
    m3 = s[31:0];
    x0 = m1;
    x1 = m2 ^ m3 ^ m1;
    x2 = m3 ^ m1;
    x3 = m0 ^ m3;
    t  = {x0,
          x1[23:0], x1[31:24],
          x2[15:0], x2[31:16],
          x3[7:0],  x3[31:8]} ^ rk;
    o  = '0;
    for (int b = 0; b < 16; b++) begin
      o[8*b +: 8] = sbox_inv(t[8*b +: 8]);
    end
    return o;
  endfunction

  // ---------------------------------------------------------------------
  // Tweakey schedule helpers. Two byte LFSRs cover all four directions:
  // TK2 forward equals TK3 backward, and TK3 forward equals TK2 backward.
  // ---------------------------------------------------------------------
  function automatic logic [7:0] lfsr_a(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5]};
  endfunction

  function automatic logic [7:0] lfsr_b(input logic [7:0] x);
    return {x[0] ^ x[6], x[7:1]};
  endfunction

  // Apply one of the byte LFSRs to the upper eight bytes only.
  function automatic logic [127:0] top_lfsr(input logic [127:0] t,
                                            input logic        use_a);
    logic [127:0] o;
    o = t;
    for (int b = 8; b < 16; b++) begin
      o[8*b +: 8] = use_a ? lfsr_a(t[8*b +: 8]) : lfsr_b(t[8*b +: 8]);
    end
    return o;
  endfunction

  function automatic logic [127:0] fwd_perm(input logic [127:0] t);
    return {t[55:48], t[7:0],   t[63:56], t[23:16],
            t[47:40], t[15:8],  t[31:24], t[39:32],
            t[127:64]};
  endfunction

  function automatic logic [127:0] inv_perm(input logic [127:0] t);
    return {t[63:0],
            t[111:104], t[127:120], t[95:88],  t[71:64],
            t[79:72],   t[103:96],  t[87:80],  t[119:112]};
  endfunction

  function automatic logic [5:0] rc_fwd(input logic [5:0] c);
    return {c[4:0], c[5] ^ c[4] ^ 1'b1};
  endfunction

  function automatic logic [5:0] rc_inv(input logic [5:0] c);
    return {c[0] ^ c[5] ^ 1'b1, c[5:1]};
  endfunction

  // Only the upper half of the tweakey reaches the state; the lower half of
  // the round key carries nothing but the fixed 0x02 constant byte.
  function automatic logic [127:0] round_key(input logic [127:0] tk3s,
                                             input logic [127:0] tkx,
                                             input logic [5:0]   c);
    logic [127:0] rk;
    rk          = {tk3s[127:64] ^ tkx[127:64], 64'h0};
    rk[123:120] = rk[123:120] ^ c[3:0];
    rk[89:88]   = rk[89:88] ^ c[5:4];
    rk[63:56]   = 8'h02;
    return rk;
  endfunction

  // Share 0 mixes TK1, share 1 mixes TK2; the round constant goes into both.
  assign rk0 = round_key(tk3_q[127:0],   tk1_q, rc_q);
  assign rk1 = round_key(tk3_q[255:128], tk2_q, rc_q);

  // Next-state, counter, datapath and schedule updates for the run sequencer.
  always_comb begin
    fsm_d  = fsm_q;
    cnt_d  = cnt_q;
    rc_d   = rc_q;
    done_d = done_q;
    st_d   = st_q;
    tk1_d  = tk1_q;
    tk2_d  = tk2_q;
    tk3_d  = tk3_q;
    case (fsm_q)
      S_IDLE: begin
        if (start_i) begin
          st_d   = cipher_i;
          tk3_d  = key_i;
          tk1_d  = tweak1_i;
          tk2_d  = tweak2_i;
          rc_d   = RC_INIT;
          cnt_d  = '0;
          done_d = 1'b0;
          fsm_d  = S_PREP;
        end
      end
      S_PREP: begin
        tk1_d = fwd_perm(tk1_q);
        tk2_d = top_lfsr(fwd_perm(tk2_q), 1'b1);
        tk3_d = {top_lfsr(fwd_perm(tk3_q[255:128]), 1'b0),
                 top_lfsr(fwd_perm(tk3_q[127:0]),   1'b0)};
        rc_d  = rc_fwd(rc_q);
        if (cnt_q == LAST_PREP) begin
          cnt_d = '0;
          fsm_d = S_DEC;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      S_DEC: begin
        st_d = {inv_round(st_q[255:128], rk1), inv_round(st_q[127:0], rk0)};
        if (cnt_q == LAST_DEC) begin
          // Round 1 has just been undone with the input tweakeys, so the
          // schedule is already back at its starting point.
          cnt_d  = '0;
          done_d = 1'b1;
          fsm_d  = S_IDLE;
        end else begin
          cnt_d = cnt_q + 6'd1;
          tk1_d = inv_perm(tk1_q);
          tk2_d = inv_perm(top_lfsr(tk2_q, 1'b0));
          tk3_d = {inv_perm(top_lfsr(tk3_q[255:128], 1'b1)),
                   inv_perm(top_lfsr(tk3_q[127:0],   1'b1))};
          rc_d  = rc_inv(rc_q);
        end
      end
      default: begin
        fsm_d = S_IDLE;
      end
    endcase
  end

  // Control and state registers; reset forces idle with a cleared output.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fsm_q  <= S_IDLE;
      cnt_q  <= '0;
      rc_q   <= RC_INIT;
      done_q <= 1'b1;
      st_q   <= '0;
    end else begin
      fsm_q  <= fsm_d;
      cnt_q  <= cnt_d;
      rc_q   <= rc_d;
      done_q <= done_d;
      st_q   <= st_d;
    end
  end

  // Tweakey registers are only meaningful after a load, so they carry no reset.
  always_ff @(posedge clk_i) begin
    tk1_q <= tk1_d;
    tk2_q <= tk2_d;
    tk3_q <= tk3_d;
  end

  assign plain_o = st_q;
  assign done_o  = done_q;

endmodule
